// File: rtl/siphash_msg_sequencer_pkg.sv
// Shared SipHash slave register map and sequencer state encoding.
// Imported by the sequencer top, its tail-pad helper and the bus interface.
package siphash_msg_sequencer_pkg;

   localparam logic [7:0] ADDR_CTRL   = 8'h08;
   localparam logic [7:0] ADDR_STATUS = 8'h09;
   localparam logic [7:0] ADDR_PARAM  = 8'h0b;
   localparam logic [7:0] ADDR_KEY0   = 8'h10;
   localparam logic [7:0] ADDR_MSG    = 8'h18;
   localparam logic [7:0] ADDR_RESULT = 8'h20;

   localparam int CTRL_INIT_BIT     = 0;
   localparam int CTRL_COMPRESS_BIT = 1;
   localparam int CTRL_FINALIZE_BIT = 2;

   localparam int STATUS_READY_BIT = 0;
   localparam int STATUS_VALID_BIT = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CFG,
      ST_KEYS,
      ST_INIT,
      ST_POLL,
      ST_ACCEPT,
      ST_WRMSG,
      ST_CMP,
      ST_PAD,
      ST_FIN,
      ST_READ
   } seq_state_e;

   function automatic logic [63:0] ctrl_cmd(input int b);
      ctrl_cmd = 64'd1 << b;
   endfunction

endpackage

// File: rtl/siphash_msg_sequencer_if.sv
// Memory-mapped bus between the sequencer (master) and the siphash slave.
// Read data is combinational from the slave in the same cycle as cs & !we.
interface siphash_msg_sequencer_if;
   import siphash_msg_sequencer_pkg::*;

   logic        sip_cs;
   logic        sip_we;
   logic [7:0]  sip_addr;
   logic [63:0] sip_write_data;
   logic [63:0] sip_read_data;

   modport master (
      output sip_cs,
      output sip_we,
      output sip_addr,
      output sip_write_data,
      input  sip_read_data
   );

   modport slave (
      input  sip_cs,
      input  sip_we,
      input  sip_addr,
      input  sip_write_data,
      output sip_read_data
   );

endinterface

// File: rtl/siphash_msg_sequencer_tail_pad.sv
// Final-beat formatter: keeps the valid low bytes and, when the word is
// short, drops the running length byte into the top byte.
module siphash_msg_sequencer_tail_pad
   import siphash_msg_sequencer_pkg::*;
(
   input  logic [63:0] data,
   input  logic [3:0]  nbytes,
   input  logic [7:0]  len,
   output logic [63:0] word,
   output logic [7:0]  len_new,
   output logic        full
);

   logic [3:0] n;

   always_comb begin
      n = (nbytes > 4'd8) ? 4'd8 : nbytes;
      full = (n == 4'd8);
      len_new = len + {4'd0, n};
      word = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(n)) begin
            word[8*i +: 8] = data[8*i +: 8];
         end
      end
      // a full last word leaves no room; the length goes in a later pad word
      if (!full) begin
         word[63:56] = len_new;
      end
   end

endmodule

// File: rtl/siphash_msg_sequencer.sv
// Drives one siphash slave through config, keys, init, per-word compress,
// finalize and result read for each message taken from the word stream.
module siphash_msg_sequencer
   import siphash_msg_sequencer_pkg::*;
#(
   parameter int POLL_TIMEOUT = 1024,
   parameter int TO_W         = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [3:0]              param_c,
   input  logic [3:0]              param_d,
   input  logic [255:0]            key,
   output logic                    busy,
   input  logic                    msg_valid,
   output logic                    msg_ready,
   input  logic [63:0]             msg_data,
   input  logic                    msg_last,
   input  logic [3:0]              msg_bytes,
   siphash_msg_sequencer_if.master sip,
   output logic [63:0]             digest,
   output logic                    digest_valid,
   output logic                    error
);

   seq_state_e state, state_n;
   seq_state_e ret_state, ret_n;

   logic         poll_valid, pv_n;
   logic         settle;
   logic [TO_W-1:0] to_cnt;
   logic [1:0]   key_idx;
   logic [7:0]   param_q;
   logic [255:0] key_q;
   logic [63:0]  word;
   logic [7:0]   len;
   logic         last_seen;
   logic         pad_pending;

   logic         cs, we;
   logic [7:0]   addr;
   logic [63:0]  wdata;
   logic         poll_enter;
   logic         timeout;
   logic         rd_done;
   logic         hit;
   logic         accept;

   logic [63:0]  pad_word;
   logic [7:0]   pad_len;
   logic         pad_full;

   siphash_msg_sequencer_tail_pad u_tail_pad (
      .data    (msg_data),
      .nbytes  (msg_bytes),
      .len     (len),
      .word    (pad_word),
      .len_new (pad_len),
      .full    (pad_full)
   );

   assign sip.sip_cs         = cs;
   assign sip.sip_we         = we;
   assign sip.sip_addr       = addr;
   assign sip.sip_write_data = wdata;

   assign hit = poll_valid ? sip.sip_read_data[STATUS_VALID_BIT]
                           : sip.sip_read_data[STATUS_READY_BIT];
   assign accept = msg_ready & msg_valid;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n    = state;
      ret_n      = ret_state;
      pv_n       = poll_valid;
      cs         = 1'b0;
      we         = 1'b0;
      addr       = '0;
      wdata      = '0;
      msg_ready  = 1'b0;
      poll_enter = 1'b0;
      timeout    = 1'b0;
      rd_done    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) state_n = ST_CFG;
         end
         ST_CFG: begin
            cs      = 1'b1;
            we      = 1'b1;
            addr    = ADDR_PARAM;
            wdata   = {56'd0, param_q};
            state_n = ST_KEYS;
         end
         ST_KEYS: begin
            cs    = 1'b1;
            we    = 1'b1;
            addr  = ADDR_KEY0 + {6'd0, key_idx};
            wdata = key_q[{key_idx, 6'd0} +: 64];
            if (key_idx == 2'd3) state_n = ST_INIT;
         end
         ST_INIT: begin
            cs         = 1'b1;
            we         = 1'b1;
            addr       = ADDR_CTRL;
            wdata      = ctrl_cmd(CTRL_INIT_BIT);
            poll_enter = 1'b1;
            ret_n      = ST_ACCEPT;
            pv_n       = 1'b0;
            state_n    = ST_POLL;
         end
         ST_POLL: begin
            // the cycle right after a command is left idle for the slave
            if (!settle) begin
               cs   = 1'b1;
               addr = ADDR_STATUS;
               if (hit) begin
                  state_n = ret_state;
               end else if (to_cnt == TO_W'(POLL_TIMEOUT - 1)) begin
                  timeout = 1'b1;
                  state_n = ST_IDLE;
               end
            end
         end
         ST_ACCEPT: begin
            msg_ready = 1'b1;
            if (msg_valid) state_n = ST_WRMSG;
         end
         ST_WRMSG: begin
            cs      = 1'b1;
            we      = 1'b1;
            addr    = ADDR_MSG;
            wdata   = word;
            state_n = ST_CMP;
         end
         ST_CMP: begin
            cs         = 1'b1;
            we         = 1'b1;
            addr       = ADDR_CTRL;
            wdata      = ctrl_cmd(CTRL_COMPRESS_BIT);
            poll_enter = 1'b1;
            pv_n       = 1'b0;
            state_n    = ST_POLL;
            if (!last_seen)      ret_n = ST_ACCEPT;
            else if (pad_pending) ret_n = ST_PAD;
            else                 ret_n = ST_FIN;
         end
         ST_PAD: begin
            state_n = ST_WRMSG;
         end
         ST_FIN: begin
            cs         = 1'b1;
            we         = 1'b1;
            addr       = ADDR_CTRL;
            wdata      = ctrl_cmd(CTRL_FINALIZE_BIT);
            poll_enter = 1'b1;
            ret_n      = ST_READ;
            pv_n       = 1'b1;
            state_n    = ST_POLL;
         end
         ST_READ: begin
            cs      = 1'b1;
            addr    = ADDR_RESULT;
            rd_done = 1'b1;
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy         <= 1'b0;
         digest       <= '0;
         digest_valid <= 1'b0;
         error        <= 1'b0;
         len          <= '0;
         param_q      <= '0;
         key_q        <= '0;
         key_idx      <= '0;
         word         <= '0;
         last_seen    <= 1'b0;
         pad_pending  <= 1'b0;
         settle       <= 1'b0;
         to_cnt       <= '0;
         ret_state    <= ST_IDLE;
         poll_valid   <= 1'b0;
      end else begin
         ret_state    <= ret_n;
         poll_valid   <= pv_n;
         digest_valid <= rd_done;
         error        <= timeout;

         if (state == ST_IDLE && start) begin
            param_q     <= {param_d, param_c};
            key_q       <= key;
            len         <= '0;
            busy        <= 1'b1;
            key_idx     <= '0;
            last_seen   <= 1'b0;
            pad_pending <= 1'b0;
         end

         if (state == ST_KEYS) key_idx <= key_idx + 2'd1;

         if (poll_enter) begin
            settle <= 1'b1;
            to_cnt <= '0;
         end else if (state == ST_POLL) begin
            settle <= 1'b0;
            if (!settle) to_cnt <= to_cnt + 1'b1;
         end

         if (accept) begin
            if (msg_last) begin
               word        <= pad_word;
               len         <= pad_len;
               last_seen   <= 1'b1;
               pad_pending <= pad_full;
            end else begin
               word <= msg_data;
               len  <= len + 8'd8;
            end
         end

         if (state == ST_PAD) begin
            word        <= {len, 56'd0};
            pad_pending <= 1'b0;
         end

         if (rd_done) begin
            digest <= sip.sip_read_data;
            busy   <= 1'b0;
         end

         if (timeout) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_siphash_msg_sequencer.sv
// Sequencer bench: behavioural siphash slave, bus write trace and a
// byte-level SipHash reference computed from the raw message.
module tb_siphash_msg_sequencer;

   localparam logic [7:0] A_CTRL   = 8'h08;
   localparam logic [7:0] A_STATUS = 8'h09;
   localparam logic [7:0] A_PARAM  = 8'h0b;
   localparam logic [7:0] A_KEY0   = 8'h10;
   localparam logic [7:0] A_MSG    = 8'h18;
   localparam logic [7:0] A_RESULT = 8'h20;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   param_c = '0;
   logic [3:0]   param_d = '0;
   logic [255:0] key = '0;
   logic         busy;
   logic         msg_valid = 1'b0;
   logic         msg_ready;
   logic [63:0]  msg_data = '0;
   logic         msg_last = 1'b0;
   logic [3:0]   msg_bytes = '0;
   logic [63:0]  digest;
   logic         digest_valid;
   logic         error;

   siphash_msg_sequencer_if sip ();

   siphash_msg_sequencer #(
      .POLL_TIMEOUT (1024),
      .TO_W         (11)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .param_c      (param_c),
      .param_d      (param_d),
      .key          (key),
      .busy         (busy),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .msg_data     (msg_data),
      .msg_last     (msg_last),
      .msg_bytes    (msg_bytes),
      .sip          (sip),
      .digest       (digest),
      .digest_valid (digest_valid),
      .error        (error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [71:0] got,
                        input logic [71:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
      return (x << r) | (x >> (64 - r));
   endfunction

   function automatic logic [255:0] sipround(input logic [255:0] s);
      logic [63:0] v0, v1, v2, v3;
      {v3, v2, v1, v0} = s;
      v0 += v1; v1 = rotl(v1, 13); v1 ^= v0; v0 = rotl(v0, 32);
      v2 += v3; v3 = rotl(v3, 16); v3 ^= v2;
      v0 += v3; v3 = rotl(v3, 21); v3 ^= v0;
      v2 += v1; v1 = rotl(v1, 17); v1 ^= v2; v2 = rotl(v2, 32);
      return {v3, v2, v1, v0};
   endfunction

   function automatic logic [255:0] sip_init(input logic [63:0] k0,
                                             input logic [63:0] k1);
      return {k1 ^ 64'h7465646279746573, k0 ^ 64'h6c7967656e657261,
              k1 ^ 64'h646f72616e646f6d, k0 ^ 64'h736f6d6570736575};
   endfunction

   function automatic logic [255:0] sip_compress(input logic [255:0] s,
                                                 input logic [63:0] m,
                                                 input int c);
      s[255:192] ^= m;
      for (int i = 0; i < c; i++) s = sipround(s);
      s[63:0] ^= m;
      return s;
   endfunction

   function automatic logic [63:0] sip_final(input logic [255:0] s,
                                             input int d);
      s[191:128] ^= 64'hff;
      for (int i = 0; i < d; i++) s = sipround(s);
      return s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
   endfunction

   // behavioural slave: random command latency, optional stuck-not-ready
   logic [63:0]  s_key [4];
   logic [7:0]   s_param = '0;
   logic [63:0]  s_msg = '0;
   logic [63:0]  s_result = '0;
   logic [255:0] s_v = '0;
   logic         s_valid = 1'b0;
   int           s_lat = 0;
   bit           force_nr = 1'b0;

   always @(posedge clk) begin
      if (s_lat > 0) s_lat <= s_lat - 1;
      if (sip.sip_cs && sip.sip_we) begin
         if (sip.sip_addr == A_PARAM) s_param <= sip.sip_write_data[7:0];
         if (sip.sip_addr[7:2] == A_KEY0[7:2])
            s_key[sip.sip_addr[1:0]] <= sip.sip_write_data;
         if (sip.sip_addr == A_MSG) s_msg <= sip.sip_write_data;
         if (sip.sip_addr == A_CTRL) begin
            s_lat <= int'($urandom_range(1, 6));
            if (sip.sip_write_data[0]) begin
               s_v     <= sip_init(s_key[0], s_key[1]);
               s_valid <= 1'b0;
            end
            if (sip.sip_write_data[1])
               s_v <= sip_compress(s_v, s_msg, int'(s_param[3:0]));
            if (sip.sip_write_data[2]) begin
               s_result <= sip_final(s_v, int'(s_param[7:4]));
               s_valid  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      sip.sip_read_data = '0;
      if (sip.sip_addr == A_STATUS)
         sip.sip_read_data = {62'd0, s_valid && s_lat == 0,
                              s_lat == 0 && !force_nr};
      else if (sip.sip_addr == A_RESULT)
         sip.sip_read_data = s_result;
   end

   logic [71:0] wr_q [$];
   int          status_reads = 0;
   bit          both_seen = 1'b0;

   always @(negedge clk) begin
      if (sip.sip_cs && sip.sip_we) begin
         wr_q.push_back({sip.sip_addr, sip.sip_write_data});
         if (sip.sip_addr == A_CTRL) status_reads = 0;
      end
      if (sip.sip_cs && !sip.sip_we && sip.sip_addr == A_STATUS)
         status_reads++;
      if (error && digest_valid) both_seen = 1'b1;
   end

   logic [7:0]  msg_q [$];
   logic [63:0] exp_words [$];
   logic [63:0] last_digest = '0;

   // SipHash message schedule: 8-byte LE words, last word carries len mod 256
   task automatic build_words();
      int n;
      logic [63:0] w;
      exp_words.delete();
      n = msg_q.size();
      for (int i = 0; i <= n / 8; i++) begin
         w = '0;
         for (int j = 0; j < 8; j++)
            if (8 * i + j < n) w[8*j +: 8] = msg_q[8*i + j];
         if (i == n / 8) w[63:56] = 8'(n);
         exp_words.push_back(w);
      end
   endtask

   function automatic logic [63:0] ref_hash(input logic [127:0] k,
                                            input int c, input int d);
      logic [255:0] s;
      s = sip_init(k[63:0], k[127:64]);
      foreach (exp_words[i]) s = sip_compress(s, exp_words[i], c);
      return sip_final(s, d);
   endfunction

   task automatic rand_msg(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
   endtask

   task automatic drive_msg(input bit gaps, output bit ok);
      int n, nb, cnt, k;
      logic [63:0] d;
      ok = 1'b1;
      n = msg_q.size();
      nb = (n == 0) ? 1 : (n + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         d = {$urandom, $urandom};
         cnt = (b == nb - 1) ? n - 8 * b : 8;
         for (int j = 0; j < cnt; j++) d[8*j +: 8] = msg_q[8*b + j];
         if (gaps && $urandom_range(0, 2) == 0) begin
            msg_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         msg_valid = 1'b1;
         msg_data  = d;
         msg_last  = (b == nb - 1);
         if (b == nb - 1)
            msg_bytes = (cnt == 8) ? 4'($urandom_range(8, 15)) : 4'(cnt);
         else
            msg_bytes = 4'($urandom);
         k = 0;
         @(negedge clk);
         while (!msg_ready && k < 200) begin
            @(negedge clk);
            k++;
         end
         if (!msg_ready) begin
            check("msg_ready_wait", 72'(msg_ready), 72'd1);
            ok = 1'b0;
            msg_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
   endtask

   task automatic run_msg(input string tag, input logic [3:0] c,
                          input logic [3:0] d, input logic [255:0] k,
                          input bit gaps, input bit poke);
      int base, kk;
      bit ok;
      logic [63:0] expd;
      logic [71:0] exp_tr [$];
      build_words();
      expd = ref_hash(k[127:0], int'(c), int'(d));
      base = wr_q.size();
      param_c = c;
      param_d = d;
      key = k;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check($sformatf("%s_busy", tag), 72'(busy), 72'd1);
      if (poke) begin
         @(posedge clk);
         #1;
         param_c = c + 4'd1;
         param_d = d + 4'd1;
         key = ~k;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      drive_msg(gaps, ok);
      kk = 0;
      @(negedge clk);
      while (!digest_valid && !error && kk < 4000) begin
         @(negedge clk);
         kk++;
      end
      check($sformatf("%s_dv", tag), 72'(digest_valid), 72'd1);
      check($sformatf("%s_err", tag), 72'(error), 72'd0);
      check($sformatf("%s_digest", tag), 72'(digest), 72'(expd));
      check($sformatf("%s_idle", tag), 72'(busy), 72'd0);
      last_digest = expd;
      exp_tr.push_back({A_PARAM, 56'd0, d, c});
      for (int i = 0; i < 4; i++)
         exp_tr.push_back({8'(A_KEY0 + 8'(i)), k[64*i +: 64]});
      exp_tr.push_back({A_CTRL, 64'd1});
      foreach (exp_words[i]) begin
         exp_tr.push_back({A_MSG, exp_words[i]});
         exp_tr.push_back({A_CTRL, 64'd2});
      end
      exp_tr.push_back({A_CTRL, 64'd4});
      check($sformatf("%s_trlen", tag), 72'(wr_q.size() - base),
            72'(exp_tr.size()));
      for (int i = 0; i < exp_tr.size(); i++)
         if (base + i < wr_q.size())
            check($sformatf("%s_tr%0d", tag, i), wr_q[base + i], exp_tr[i]);
      @(negedge clk);
      check($sformatf("%s_dvpulse", tag), 72'(digest_valid), 72'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   localparam logic [255:0] STD_KEY =
      {128'h0, 128'h0f0e0d0c0b0a09080706050403020100};

   initial begin
      int base, kk;
      logic [255:0] rk;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_busy", 72'(busy), 72'd0);
      check("rst_ready", 72'(msg_ready), 72'd0);
      check("rst_cs", 72'(sip.sip_cs), 72'd0);
      check("rst_we", 72'(sip.sip_we), 72'd0);
      check("rst_dv", 72'(digest_valid), 72'd0);
      check("rst_err", 72'(error), 72'd0);
      check("rst_digest", 72'(digest), 72'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // empty message, standard key, SipHash-2-4 reference vector
      msg_q.delete();
      run_msg("empty", 4'd2, 4'd4, STD_KEY, 1'b0, 1'b0);
      check("empty_vector", 72'(digest), 72'h726fdb47dd0e0e31);

      msg_q.delete();
      for (int i = 0; i < 15; i++) msg_q.push_back(8'(i));
      run_msg("b15", 4'd2, 4'd4, STD_KEY, 1'b0, 1'b0);

      msg_q.delete();
      for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
      run_msg("b16", 4'd2, 4'd4, STD_KEY, 1'b1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         rand_msg(int'($urandom_range(0, 40)));
         rk = {$urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom};
         run_msg($sformatf("rnd%0d", r), 4'($urandom_range(1, 4)),
                 4'($urandom_range(1, 4)), rk, 1'b1, r[0]);
      end

      rand_msg(263);
      run_msg("wrap", 4'd1, 4'd2, {8{$urandom}}, 1'b1, 1'b0);

      // slave never reports ready: must give up after exactly 1024 reads
      force_nr = 1'b1;
      base = wr_q.size();
      param_c = 4'd2;
      param_d = 4'd4;
      key = STD_KEY;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      kk = 0;
      @(negedge clk);
      while (!error && kk < 1500) begin
         @(negedge clk);
         kk++;
      end
      check("to_error", 72'(error), 72'd1);
      check("to_reads", 72'(status_reads), 72'd1024);
      check("to_busy", 72'(busy), 72'd0);
      check("to_cs", 72'(sip.sip_cs), 72'd0);
      check("to_dv", 72'(digest_valid), 72'd0);
      check("to_digest", 72'(digest), 72'(last_digest));
      check("to_trlen", 72'(wr_q.size() - base), 72'd6);
      @(negedge clk);
      check("to_pulse", 72'(error), 72'd0);
      force_nr = 1'b0;
      @(posedge clk);
      #1;

      // reset in the middle of the first compress
      rand_msg(40);
      base = wr_q.size();
      param_c = 4'd3;
      param_d = 4'd5;
      key = {8{$urandom}};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      msg_valid = 1'b1;
      msg_data = {$urandom, $urandom};
      msg_last = 1'b0;
      kk = 0;
      @(negedge clk);
      while (wr_q.size() - base < 8 && kk < 200) begin
         @(negedge clk);
         kk++;
      end
      check("mid_cmp_seen", 72'(wr_q.size() - base >= 8), 72'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      msg_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_busy", 72'(busy), 72'd0);
      check("mid_ready", 72'(msg_ready), 72'd0);
      check("mid_cs", 72'(sip.sip_cs), 72'd0);
      check("mid_digest", 72'(digest), 72'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_digest = '0;
      @(posedge clk);
      #1;
      run_msg("after_rst", 4'd3, 4'd5, {8{$urandom}}, 1'b1, 1'b1);

      check("err_dv_exclusive", 72'(both_seen), 72'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
